// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial Galois-LFSR CRC over framed bytes, MSB-first, one bit per clock.
// Optional CRC8_SERIAL_CHECK_EN adds crc_expected/crc_ok result comparison.
module crc8_serial #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = 8'h07,
  parameter logic [WIDTH-1:0] INIT = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eof,
  output logic             in_ready,
  output logic             busy,
  output logic [WIDTH-1:0] crc_out,
  output logic             crc_valid
`ifdef CRC8_SERIAL_CHECK_EN
  ,
  input  logic [WIDTH-1:0] crc_expected,
  output logic             crc_ok
`endif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] crc_q, crc_d, sh_q, sh_d, out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             eof_q, eof_d, vld_q, vld_d, fb;
  assign in_ready  = (state_q == IDLE) & ~rst;
  assign busy      = (state_q != IDLE);
  assign crc_out   = out_q;
  assign crc_valid = vld_q;
  assign fb        = crc_q[WIDTH-1] ^ sh_q[WIDTH-1];
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    eof_d   = eof_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        sh_d    = in_data;
        eof_d   = in_eof;
        cnt_d   = CW'(WIDTH - 1);
        crc_d   = in_sof ? INIT : crc_q;
        state_d = SHIFT;
      end
      SHIFT: begin
        crc_d   = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        sh_d    = {sh_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? (eof_q ? DONE : IDLE) : SHIFT;
      end
      DONE: begin
        out_d   = crc_q;
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      sh_q    <= '0;
      cnt_q   <= '0;
      eof_q   <= 1'b0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      eof_q   <= eof_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end
`ifdef CRC8_SERIAL_CHECK_EN
  logic ok_q;
  assign crc_ok = ok_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ok_q <= 1'b0;
    else if (state_q == DONE) ok_q <= (crc_q == crc_expected);
  end
`endif
endmodule

// File: tb/tb_crc8_serial.sv
// tb_crc8_serial: directed bench with a scoreboard of expected frame CRCs.
module tb_crc8_serial;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
  logic       in_ready, busy, crc_valid;
  logic [7:0] crc_out;
`ifdef CRC8_SERIAL_CHECK_EN
  logic [7:0] crc_expected = '0;
  logic       crc_ok;
  logic       ok_q[$];
`endif
  logic [7:0] exp_q[$];
  logic [7:0] model = 8'h00;
  logic [7:0] msg[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  int         n_assert = 0, n_fail = 0, pulses = 0, p0;

  always #5 clk = ~clk;

  crc8_serial dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_eof(in_eof), .in_ready(in_ready), .busy(busy), .crc_out(crc_out), .crc_valid(crc_valid)
`ifdef CRC8_SERIAL_CHECK_EN
    , .crc_expected(crc_expected), .crc_ok(crc_ok)
`endif
  );

  function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] d);
    for (int i = 7; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a byte and hold it until accepted; in_valid stays high afterwards.
  task automatic send(input logic [7:0] d, input logic s, input logic e);
    int t = 0;
    @(negedge clk);
    in_data = d; in_sof = s; in_eof = e; in_valid = 1'b1;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    chk("accept_timeout", {7'b0, in_ready}, 8'h01);
    @(posedge clk);
    if (s) model = 8'h00;
    model = crc_byte(model, d);
    if (e) begin
      exp_q.push_back(model);
`ifdef CRC8_SERIAL_CHECK_EN
      ok_q.push_back(model == crc_expected);
`endif
    end
  endtask

  task automatic send_frame();
    for (int i = 0; i < 9; i++) send(msg[i], i == 0, i == 8);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 40) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("drain_timeout", 8'(exp_q.size()), 8'h00);
  endtask

  always @(negedge clk) if (crc_valid) begin
    pulses++;
    if (exp_q.size() == 0) chk("unexpected_crc_valid", 8'h01, 8'h00);
    else chk("scoreboard_crc", crc_out, exp_q.pop_front());
`ifdef CRC8_SERIAL_CHECK_EN
    if (ok_q.size() != 0) chk("scoreboard_ok", {7'b0, crc_ok}, {7'b0, ok_q.pop_front()});
`endif
  end

  initial begin
    #1;
    chk("rst_in_ready", {7'b0, in_ready}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_crc_valid", {7'b0, crc_valid}, 8'h00);
    chk("rst_crc_out", crc_out, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // latency: accept at T, in_ready low 9 cycles, strobe after edge T+9
    send(8'h01, 1'b1, 1'b1);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("lat_ready_low_%0d", k), {7'b0, in_ready}, 8'h00);
      chk($sformatf("lat_busy_%0d", k), {7'b0, busy}, 8'h01);
      chk($sformatf("lat_no_valid_%0d", k), {7'b0, crc_valid}, 8'h00);
    end
    @(negedge clk);
    chk("lat_valid", {7'b0, crc_valid}, 8'h01);
    chk("lat_crc_01", crc_out, 8'h07);
    chk("lat_ready_back", {7'b0, in_ready}, 8'h01);
    @(negedge clk);
    chk("strobe_one_cycle", {7'b0, crc_valid}, 8'h00);
    chk("crc_out_held", crc_out, 8'h07);
    send(8'h80, 1'b1, 1'b1);
    #1 in_valid = 1'b0;
    drain();
    chk("crc_80", crc_out, 8'h89);
    send(8'h00, 1'b1, 1'b1);
    #1 in_valid = 1'b0;
    drain();
    chk("crc_00", crc_out, 8'h00);
    p0 = pulses;
    send_frame();
    drain();
    chk("crc_check_string", crc_out, 8'hF4);
    chk("check_string_pulses", 8'(pulses - p0), 8'h01);
    // sof mid-frame aborts the open frame
    p0 = pulses;
    send(8'h31, 1'b1, 1'b0);
    send(8'h32, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b1);
    #1 in_valid = 1'b0;
    drain();
    chk("abort_crc", crc_out, 8'h07);
    chk("abort_pulses", 8'(pulses - p0), 8'h01);
    // reset during the shift of byte 3
    p0 = pulses;
    send(8'h31, 1'b1, 1'b0);
    send(8'h32, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {7'b0, busy}, 8'h00);
    chk("midrst_in_ready", {7'b0, in_ready}, 8'h00);
    chk("midrst_crc_valid", {7'b0, crc_valid}, 8'h00);
    chk("midrst_crc_out", crc_out, 8'h00);
    model = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_no_pulse", 8'(pulses - p0), 8'h00);
    send_frame();
    drain();
    chk("midrst_resend_crc", crc_out, 8'hF4);
    // non-sof byte right after reset continues from INIT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model = 8'h00;
    send(8'h80, 1'b0, 1'b1);
    #1 in_valid = 1'b0;
    drain();
    chk("nosof_after_rst", crc_out, 8'h89);
`ifdef CRC8_SERIAL_CHECK_EN
    crc_expected = 8'hF4;
    send_frame();
    drain();
    chk("check_ok_match", {7'b0, crc_ok}, 8'h01);
    crc_expected = 8'hF5;
    send_frame();
    drain();
    chk("check_ok_mismatch", {7'b0, crc_ok}, 8'h00);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
